// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Measures an incoming PWM waveform and recovers its duty cycle as an 8-bit
// value (0 = 0 %, 255 = ~100 %). Once per PWM period it publishes the measured
// high time, the period and floor(high*256/period), with a one-cycle strobe.
// A line that shows no rising edge for TIMEOUT_CYCLES is reported as stuck.
//
// Optional feature (compile-time macro PWM_CAPTURE_GLITCH_FILTER_EN):
//   when defined, the synchronized input must hold a new level for FILT_LEN
//   consecutive cycles before the internal line level follows it. Both edges
//   are delayed equally, so measured high time and period are unchanged.
//
// Parameters:
//   CNT_W          width of the period / high-time counters (clock cycles)
//   TIMEOUT_CYCLES cycles without a rising edge before a stuck line is declared
//   FILT_LEN       glitch filter length (used only with the filter compiled in)
//
// Ports:
//   clock_in     in   system clock
//   reset_in     in   asynchronous, active-high reset
//   pwm_in       in   asynchronous PWM input
//   value_out    out  [7:0]       duty, floor(high*256/period), saturated to 255
//   high_out     out  [CNT_W-1:0] high cycles of the last complete period
//   period_out   out  [CNT_W-1:0] cycles between the last two rising edges
//   valid_out    out  one-cycle strobe: the three result outputs updated
//   timeout_out  out  level, high while the line is stuck
//   overrun_out  out  one-cycle strobe: a measurement was dropped
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 60000,
  parameter int unsigned FILT_LEN       = 3
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             pwm_in,
  output logic [7:0]       value_out,
  output logic [CNT_W-1:0] high_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid_out,
  output logic             timeout_out,
  output logic             overrun_out
);

  localparam int unsigned       NUM_W        = CNT_W + 8;
  localparam int unsigned       ITER_W       = $clog2(NUM_W);
  localparam logic [CNT_W-1:0]  CNT_MAX      = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ITER_W-1:0] ITER_LAST    = ITER_W'(NUM_W - 1);

  // The idle counter must be able to represent TIMEOUT_CYCLES, and a zero
  // filter length or timeout would make the comparisons above meaningless.
  if ((64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W)) || (TIMEOUT_CYCLES == 0) ||
      (FILT_LEN == 0)) begin : g_bad_params
    $error("pwm_capture: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Input path: two-flop synchronizer, optional glitch filter, edge register.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       s;
  logic       rise;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int unsigned FILT_CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic               filt_s_q, filt_s_d;
  logic [FILT_CW-1:0] filt_cnt_q, filt_cnt_d;

  // Count consecutive cycles in which the synchronized input disagrees with
  // the filtered level; any agreement restarts the count, so short pulses die.
  always_comb begin
    filt_s_d   = filt_s_q;
    filt_cnt_d = '0;
    if (sync_q[1] != filt_s_q) begin
      if (filt_cnt_q == FILT_CW'(FILT_LEN - 1)) begin
        filt_s_d = sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_CW'(1);
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      filt_s_q   <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      filt_s_q   <= filt_s_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign s = filt_s_q;
`else
  assign s = sync_q[1];
`endif

  assign sync_d = {sync_q[0], pwm_in};
  assign prev_d = s;
  assign rise   = s & ~prev_q;

  // ---------------------------------------------------------------------------
  // Measurement FSM, divider and output registers.
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;

  logic              div_busy_q, div_busy_d;
  logic [ITER_W-1:0] div_iter_q, div_iter_d;
  logic [NUM_W-1:0]  quo_q, quo_d;        // numerator shifts out, quotient shifts in
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  den_q, den_d;        // latched period, also published
  logic [CNT_W-1:0]  meas_high_q, meas_high_d;

  logic [7:0]        value_q, value_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;

  logic              close;
  logic [CNT_W:0]    rem_sh;
  logic [CNT_W-1:0]  rem_step;
  logic [NUM_W-1:0]  quo_step;
  logic [7:0]        quo_sat;

  // One restoring-division step: bring down the next numerator bit and
  // subtract the divisor when it fits.
  always_comb begin
    rem_sh = {rem_q, quo_q[NUM_W-1]};
    if (rem_sh >= {1'b0, den_q}) begin
      rem_step = CNT_W'(rem_sh - {1'b0, den_q});
      quo_step = {quo_q[NUM_W-2:0], 1'b1};
    end else begin
      rem_step = rem_sh[CNT_W-1:0];
      quo_step = {quo_q[NUM_W-2:0], 1'b0};
    end
    quo_sat = (|quo_step[NUM_W-1:8]) ? 8'hFF : quo_step[7:0];
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    div_busy_d   = div_busy_q;
    div_iter_d   = div_iter_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    den_d        = den_q;
    meas_high_d  = meas_high_q;
    value_d      = value_q;
    high_d       = high_q;
    period_d     = period_q;
    timeout_d    = timeout_q;
    valid_d      = 1'b0;
    overrun_d    = 1'b0;
    close        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        if (rise) begin
          period_cnt_d = CNT_W'(1);
          high_cnt_d   = CNT_W'(1);
          state_d      = ST_HIGH;
        end
      end
      ST_HIGH: begin
        period_cnt_d = sat_inc(period_cnt_q);
        if (s) begin
          high_cnt_d = sat_inc(high_cnt_q);
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (rise) begin
          // The rise cycle belongs to the next period, so counters restart at 1.
          close        = 1'b1;
          period_cnt_d = CNT_W'(1);
          high_cnt_d   = CNT_W'(1);
          state_d      = ST_HIGH;
        end else begin
          period_cnt_d = sat_inc(period_cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (div_busy_q) begin
      quo_d      = quo_step;
      rem_d      = rem_step;
      div_iter_d = div_iter_q + ITER_W'(1);
      if (div_iter_q == ITER_LAST) begin
        div_busy_d = 1'b0;
        value_d    = quo_sat;
        high_d     = meas_high_q;
        period_d   = den_q;
        valid_d    = 1'b1;
        timeout_d  = 1'b0;
      end
    end

    if (close) begin
      if (div_busy_q) begin
        // The in-flight result is kept; the new measurement is simply dropped.
        overrun_d = 1'b1;
      end else begin
        div_busy_d  = 1'b1;
        div_iter_d  = '0;
        quo_d       = {high_cnt_q, 8'h00};
        rem_d       = '0;
        den_d       = period_cnt_q;
        meas_high_d = high_cnt_q;
      end
    end

    // Idle watchdog. It parks at TIMEOUT_VAL after firing so the stuck report
    // strobes only once; a rise in the firing cycle takes precedence.
    if (rise) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == TIMEOUT_LAST) begin
      idle_cnt_d   = TIMEOUT_VAL;
      state_d      = ST_IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      div_busy_d   = 1'b0;
      value_d      = s ? 8'hFF : 8'h00;
      high_d       = '0;
      period_d     = '0;
      valid_d      = 1'b1;
      timeout_d    = 1'b1;
    end else if (idle_cnt_q != TIMEOUT_VAL) begin
      idle_cnt_d = idle_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking ones
  // here would race against every process reading the old register values.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      // NOTE: the divider datapath is cleared along with the control flops so
      // a reset mid-divide can never surface a stale quotient later.
      sync_q       <= '0;
      prev_q       <= 1'b0;
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      div_busy_q   <= 1'b0;
      div_iter_q   <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      den_q        <= '0;
      meas_high_q  <= '0;
      value_q      <= '0;
      high_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      div_busy_q   <= div_busy_d;
      div_iter_q   <= div_iter_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      den_q        <= den_d;
      meas_high_q  <= meas_high_d;
      value_q      <= value_d;
      high_q       <= high_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  assign value_out   = value_q;
  assign high_out    = high_q;
  assign period_out  = period_q;
  assign valid_out   = valid_q;
  assign timeout_out = timeout_q;
  assign overrun_out = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//
// Drives directed and random PWM patterns cycle by cycle. A reference model
// works purely on the driven waveform (rise times, high counts, arithmetic
// duty) and queues the results the DUT must publish; every DUT strobe is
// matched against the head of that queue, including its arrival cycle.
// The timeout is shortened to keep the run short.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CNT_W    = 16;
  localparam int T        = 3000;
  localparam int FILT_LEN = 3;
  localparam int DIV_LAT  = CNT_W + 8;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int SYNC_LAT = 2 + FILT_LEN;
`else
  localparam int SYNC_LAT = 2;
`endif
  // Drive cycle of a rise to the sample that shows its result strobe.
  localparam int RES_LAT  = SYNC_LAT + DIV_LAT;

  logic             clock_in = 1'b0;
  logic             reset_in;
  logic             pwm_in;
  logic [7:0]       value_out;
  logic [CNT_W-1:0] high_out;
  logic [CNT_W-1:0] period_out;
  logic             valid_out;
  logic             timeout_out;
  logic             overrun_out;

  pwm_capture #(
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(T),
    .FILT_LEN      (FILT_LEN)
  ) dut (
    .clock_in   (clock_in),
    .reset_in   (reset_in),
    .pwm_in     (pwm_in),
    .value_out  (value_out),
    .high_out   (high_out),
    .period_out (period_out),
    .valid_out  (valid_out),
    .timeout_out(timeout_out),
    .overrun_out(overrun_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    int   value;
    int   high;
    int   period;
    logic tmo;
    int   due;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_exp_ovr  = 0;
  int n_seen_ovr = 0;

  // Reference model state, in drive-cycle time.
  bit m_level;
  bit m_armed;
  bit m_from_reset;
  bit m_tmo_done;
  int m_last_rise;
  int m_last_accept;
  int m_high_acc;
  int m_idle;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_level       = 1'b0;
    m_armed       = 1'b0;
    m_from_reset  = 1'b1;
    m_tmo_done    = 1'b0;
    m_last_rise   = 0;
    m_last_accept = -100000;
    m_high_acc    = 0;
    m_idle        = 0;
    cyc           = 0;
  endtask

  task automatic model_step(input bit level);
    exp_t e;
    int   p;
    int   h;
    if (level && !m_level) begin
      if (m_armed) begin
        p = cyc - m_last_rise;
        h = m_high_acc;
        if (cyc - m_last_accept > DIV_LAT) begin
          e.value  = (h * 256) / p;
          if (e.value > 255) e.value = 255;
          e.high   = h;
          e.period = p;
          e.tmo    = 1'b0;
          e.due    = cyc + RES_LAT;
          exp_q.push_back(e);
          m_last_accept = cyc;
        end else begin
          n_exp_ovr++;
        end
      end
      m_armed      = 1'b1;
      m_last_rise  = cyc;
      m_high_acc   = 0;
      m_idle       = 0;
      m_from_reset = 1'b0;
      m_tmo_done   = 1'b0;
    end else if (!m_tmo_done) begin
      m_idle++;
      if (m_idle == T) begin
        e.value  = level ? 255 : 0;
        e.high   = 0;
        e.period = 0;
        e.tmo    = 1'b1;
        e.due    = cyc + (m_from_reset ? 0 : SYNC_LAT);
        exp_q.push_back(e);
        m_armed       = 1'b0;
        m_tmo_done    = 1'b1;
        m_last_accept = -100000;
      end
    end
    if (level) m_high_acc++;
    m_level = level;
  endtask

  task automatic observe();
    exp_t e;
    if (valid_out === 1'b1) begin
      n_valid++;
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_valid: strobe seen at cycle %0d, expected none", cyc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("value_out", 32'(value_out), e.value);
        check("high_out", 32'(high_out), e.high);
        check("period_out", 32'(period_out), e.period);
        check("timeout_out", 32'(timeout_out), 32'(e.tmo));
        check("strobe_cycle", cyc, e.due);
      end
    end
    if (overrun_out === 1'b1) n_seen_ovr++;
  endtask

  // raw drives the pin; seen is the level the filtered line is meant to show.
  task automatic step_raw(input bit raw, input bit seen);
    pwm_in = raw;
    @(posedge clock_in);
    #1;
    cyc++;
    model_step(seen);
    observe();
  endtask

  task automatic step(input bit level);
    step_raw(level, level);
  endtask

  task automatic pulse(input int h, input int l);
    repeat (h) step(1'b1);
    repeat (l) step(1'b0);
  endtask

  int v0;
  int hi_r;
  int lo_r;

  initial begin
    // ---------------- reset ----------------
    reset_in = 1'b1;
    pwm_in   = 1'b0;
    repeat (3) @(posedge clock_in);
    #1;
    check("rst_value", 32'(value_out), 0);
    check("rst_high", 32'(high_out), 0);
    check("rst_period", 32'(period_out), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_timeout", 32'(timeout_out), 0);
    check("rst_overrun", 32'(overrun_out), 0);
    model_reset();
    reset_in = 1'b0;

    // ---------------- idle line times out once ----------------
    v0 = n_valid;
    for (int i = 0; i < T + 200; i++) begin
      step(1'b0);
      if (cyc == T - 1) begin
        check("pre_timeout_level", 32'(timeout_out), 0);
        check("pre_timeout_valid_count", n_valid - v0, 0);
      end
    end
    check("idle_strobe_count", n_valid - v0, 1);
    check("idle_timeout_level", 32'(timeout_out), 1);

    // ---------------- square wave 1280 / 640 ----------------
    repeat (5) pulse(640, 640);

    // ---------------- duty sweep ----------------
    pulse(5, 1275);
    pulse(500, 780);
    pulse(1275, 5);
    pulse(497, 3);

    // ---------------- overrun: period 10 / high 5 ----------------
    repeat (6) pulse(5, 5);

    // ---------------- random periods ----------------
    for (int i = 0; i < 8; i++) begin
      hi_r = $urandom_range(700, 20);
      lo_r = $urandom_range(700, 20);
      pulse(hi_r, lo_r);
    end
    check("overrun_count", n_seen_ovr, n_exp_ovr);

    // ---------------- stuck high, then recover at 1280 / 320 ----------------
    repeat (T + 100) step(1'b1);
    check("stuck_timeout_level", 32'(timeout_out), 1);
    check("stuck_value", 32'(value_out), 255);
    repeat (960) step(1'b0);
    pulse(320, 960);
    pulse(320, 960);
    pulse(300, 500);
    check("recovered_timeout_level", 32'(timeout_out), 0);
    check("recovered_value", 32'(value_out), 64);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // ---------------- 2-cycle glitch in the low phase is ignored ----------------
    pulse(640, 640);
    repeat (640) step(1'b1);
    repeat (300) step(1'b0);
    repeat (2) step_raw(1'b1, 1'b0);
    repeat (338) step(1'b0);
    pulse(640, 640);
    pulse(300, 500);
    check("glitch_value", 32'(value_out), 128);
`endif

    check("results_drained", exp_q.size(), 0);
    check("overrun_count_final", n_seen_ovr, n_exp_ovr);

    // ---------------- async reset mid-divide ----------------
    repeat (10) step(1'b1);
    #2;
    reset_in = 1'b1;
    pwm_in   = 1'b0;
    #1;
    check("midrst_value", 32'(value_out), 0);
    check("midrst_high", 32'(high_out), 0);
    check("midrst_period", 32'(period_out), 0);
    check("midrst_valid", 32'(valid_out), 0);
    check("midrst_timeout", 32'(timeout_out), 0);
    @(posedge clock_in);
    #1;
    model_reset();
    reset_in = 1'b0;
    v0 = n_valid;
    repeat (100) step(1'b0);
    check("post_reset_strobes", n_valid - v0, 0);
    check("post_reset_value", 32'(value_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
